// File: rtl/seq_stage_ctrl.sv
// Sequencing controller for the Y86-64 SEQ datapath: owns PC, status and counters.
// Latency: 6 cycles per instruction minimum, plus one cycle per data-memory wait cycle.
// Backpressure: mem_ready low holds MEMORY (mem_req stays high) until MEM_TIMEOUT expires.
//
// Ports:
//   clock, reset        : single clock, synchronous active-high reset (highest priority)
//   start               : leaves IDLE; ignored in every other state
//   flag_halt, in_error,
//   bad_mem             : fetch-stage outcomes, looked at only in FETCH
//   bad_mem2, mem_ready : data-memory outcome/handshake, looked at only in MEMORY
//   p_ctr_final         : next PC from pc_update, loaded when leaving PCUPD
//   p_ctr               : architectural PC driven to fetch
//   stage_en            : one-hot stage enable (fetch..pc update = bit0..bit5)
//   mem_req             : high for every MEMORY cycle
//   stat                : one-hot status 1000 AOK, 0010 HLT, 0001 ADR, 0100 INS
//   done                : machine stopped
//   retired, cycles     : saturating instruction and active-cycle counters

module seq_stage_ctrl #(
  parameter int                  PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  MEM_TIMEOUT = 15,
  parameter int                  CNT_WIDTH   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 flag_halt,
  input  logic                 in_error,
  input  logic                 bad_mem,
  input  logic                 bad_mem2,
  input  logic                 mem_ready,
  input  logic [PC_WIDTH-1:0]  p_ctr_final,
  output logic [PC_WIDTH-1:0]  p_ctr,
  output logic [5:0]           stage_en,
  output logic                 mem_req,
  output logic [3:0]           stat,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [CNT_WIDTH-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALTED    = 3'd7
  } state_t;

  localparam logic [3:0] ST_AOK = 4'b1000;
  localparam logic [3:0] ST_HLT = 4'b0010;
  localparam logic [3:0] ST_ADR = 4'b0001;
  localparam logic [3:0] ST_INS = 4'b0100;

  // The wait counter only has to reach MEM_TIMEOUT-1: the cycle that would
  // take it to MEM_TIMEOUT is the one that declares the fault instead.
  localparam int                WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      p_ctr    <= RESET_PC;
      stat     <= ST_AOK;
      retired  <= '0;
      cycles   <= '0;
      wait_cnt <= '0;
    end else begin
      // Active cycles are those spent in the six stage states.
      if (state != S_IDLE && state != S_HALTED) begin
        cycles <= sat_inc(cycles);
      end

      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end

        S_FETCH: begin
          // Instruction-address error outranks invalid opcode, which outranks halt.
          if (bad_mem) begin
            stat  <= ST_ADR;
            state <= S_HALTED;
          end else if (in_error) begin
            stat  <= ST_INS;
            state <= S_HALTED;
          end else if (flag_halt) begin
            stat    <= ST_HLT;
            retired <= sat_inc(retired);
            state   <= S_HALTED;
          end else begin
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          state <= S_EXECUTE;
        end

        S_EXECUTE: begin
          wait_cnt <= '0;
          state    <= S_MEMORY;
        end

        S_MEMORY: begin
          // A ready response on the last allowed cycle still completes.
          if (bad_mem2) begin
            stat  <= ST_ADR;
            state <= S_HALTED;
          end else if (mem_ready) begin
            state <= S_WRITEBACK;
          end else if (wait_cnt == WAIT_LAST) begin
            stat  <= ST_ADR;
            state <= S_HALTED;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_WRITEBACK: begin
          state <= S_PCUPD;
        end

        S_PCUPD: begin
          p_ctr   <= p_ctr_final;
          retired <= sat_inc(retired);
          state   <= S_FETCH;
        end

        S_HALTED: begin
          state <= S_HALTED;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore outputs: a pure decode of the state register.
  always_comb begin
    stage_en = 6'b000000;
    mem_req  = 1'b0;
    done     = 1'b0;
    case (state)
      S_FETCH:     stage_en = 6'b000001;
      S_DECODE:    stage_en = 6'b000010;
      S_EXECUTE:   stage_en = 6'b000100;
      S_MEMORY: begin
        stage_en = 6'b001000;
        mem_req  = 1'b1;
      end
      S_WRITEBACK: stage_en = 6'b010000;
      S_PCUPD:     stage_en = 6'b100000;
      S_HALTED:    done     = 1'b1;
      default: begin
        stage_en = 6'b000000;
      end
    endcase
  end

endmodule
